// File: rtl/i2c_slave.sv
// ============================================================================
// i2c_slave
// ----------------------------------------------------------------------------
// Single-address I2C target with 7-bit addressing. Everything runs on clk:
// SCL and SDA are oversampled through 2-flop synchronizers plus a registered
// previous value. START, STOP and SCL edges are detected from that pipeline.
// The target matches its address, ACKs, and moves bytes over a small
// parallel user interface. SCL is observed only; the clock is never stretched.
//
// Ports
//   clk        in   system clock, at least 16x the SCL frequency
//   rst        in   asynchronous active-high reset
//   scl        in   bus clock (observed only)
//   sda        io   bus data; driven 1'b0 or released ('z), never 1'b1
//   rx_data    out  last byte written by the master
//   rx_valid   out  one-cycle pulse, same cycle rx_data updates
//   tx_data    in   byte returned on the next master read
//   tx_req     out  one-cycle pulse when tx_data was captured for sending
//   rw         out  R/W bit of the last matched address (1 = master read)
//   busy       out  high from address match until STOP, repeated START
//                   or read-NACK
//   start_tick out  one-cycle pulse on START / repeated START
//   stop_tick  out  one-cycle pulse on STOP
//   state_dbg  out  current FSM state encoding, for checkers
//
// User handshake: there is no backpressure in either direction.
//   rx_valid is a pure strobe. rx_data holds its value until the next strobe.
//   tx_req is a strobe that reports tx_data was just sampled. The user may
//   change tx_data only in the cycle after tx_req and must hold it stable
//   otherwise.
// ============================================================================
module i2c_slave #(
   parameter logic [6:0] SLV_ADDR = 7'h50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl,
   inout  wire        sda,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_req,
   output logic       rw,
   output logic       busy,
   output logic       start_tick,
   output logic       stop_tick,
   output logic [2:0] state_dbg
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ADDR     = 3'd1,
      ST_ADDR_ACK = 3'd2,
      ST_WR_BYTE  = 3'd3,
      ST_WR_ACK   = 3'd4,
      ST_RD_BYTE  = 3'd5,
      ST_RD_ACK   = 3'd6,
      ST_IGNORE   = 3'd7
   } state_t;

   // ------------------------------------------------------------------------
   // Synchronizers and edge detection. The flops reset to 1 so that an idle
   // bus (both lines high) does not produce a phantom edge after reset.
   // ------------------------------------------------------------------------
   logic scl_meta_q, scl_sync_q, scl_prev_q;
   logic sda_meta_q, sda_sync_q, sda_prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_meta_q <= 1'b1;
         scl_sync_q <= 1'b1;
         scl_prev_q <= 1'b1;
         sda_meta_q <= 1'b1;
         sda_sync_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_meta_q <= scl;
         scl_sync_q <= scl_meta_q;
         scl_prev_q <= scl_sync_q;
         sda_meta_q <= sda;
         sda_sync_q <= sda_meta_q;
         sda_prev_q <= sda_sync_q;
      end
   end

   logic scl_rise, scl_fall, start_det, stop_det;

   assign scl_rise  = scl_sync_q & ~scl_prev_q;
   assign scl_fall  = ~scl_sync_q & scl_prev_q;
   // SDA edges only count as START/STOP while SCL is high across both samples.
   assign start_det = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
   assign stop_det  = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;

   // ------------------------------------------------------------------------
   // FSM and datapath registers
   // ------------------------------------------------------------------------
   state_t     state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic       sda_oe_q, sda_oe_d;
   // ACK states: set once the first SCL fall has been seen (ACK driven or
   // master ACK sampled), so the next fall ends the acknowledge slot.
   logic       phase_q, phase_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       tx_req_q, tx_req_d;
   logic       rw_q, rw_d;
   logic       busy_q, busy_d;
   logic       start_tick_q, start_tick_d;
   logic       stop_tick_q, stop_tick_d;

   logic [7:0] shift_in;
   assign shift_in = {shift_q[6:0], sda_sync_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         bit_cnt_q    <= 3'd0;
         shift_q      <= 8'h00;
         sda_oe_q     <= 1'b0;
         phase_q      <= 1'b0;
         rx_data_q    <= 8'h00;
         rx_valid_q   <= 1'b0;
         tx_req_q     <= 1'b0;
         rw_q         <= 1'b0;
         busy_q       <= 1'b0;
         start_tick_q <= 1'b0;
         stop_tick_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         sda_oe_q     <= sda_oe_d;
         phase_q      <= phase_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         tx_req_q     <= tx_req_d;
         rw_q         <= rw_d;
         busy_q       <= busy_d;
         start_tick_q <= start_tick_d;
         stop_tick_q  <= stop_tick_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      sda_oe_d     = sda_oe_q;
      phase_d      = phase_q;
      rx_data_d    = rx_data_q;
      rx_valid_d   = 1'b0;
      tx_req_d     = 1'b0;
      rw_d         = rw_q;
      busy_d       = busy_q;
      start_tick_d = 1'b0;
      stop_tick_d  = 1'b0;

      if (start_det) begin
         // START and repeated START restart address reception from any state.
         bit_cnt_d    = 3'd0;
         sda_oe_d     = 1'b0;
         busy_d       = 1'b0;
         phase_d      = 1'b0;
         start_tick_d = 1'b1;
         state_d      = ST_ADDR;
      end else if (stop_det) begin
         sda_oe_d    = 1'b0;
         busy_d      = 1'b0;
         phase_d     = 1'b0;
         stop_tick_d = 1'b1;
         state_d     = ST_IDLE;
      end else begin
         case (state_q)
            ST_ADDR: begin
               if (scl_rise) begin
                  shift_d   = shift_in;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     if (shift_in[7:1] == SLV_ADDR) begin
                        rw_d    = shift_in[0];
                        busy_d  = 1'b1;
                        phase_d = 1'b0;
                        state_d = ST_ADDR_ACK;
                     end else begin
                        state_d = ST_IGNORE;
                     end
                  end
               end
            end

            ST_ADDR_ACK: begin
               if (scl_fall) begin
                  if (!phase_q) begin
                     // Fall that ends the R/W bit: start driving the ACK.
                     sda_oe_d = 1'b1;
                     phase_d  = 1'b1;
                  end else begin
                     // Fall that ends the ACK slot.
                     phase_d   = 1'b0;
                     bit_cnt_d = 3'd0;
                     if (!rw_q) begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_WR_BYTE;
                     end else begin
                        shift_d  = tx_data;
                        tx_req_d = 1'b1;
                        sda_oe_d = ~tx_data[7];
                        state_d  = ST_RD_BYTE;
                     end
                  end
               end
            end

            ST_WR_BYTE: begin
               if (scl_rise) begin
                  shift_d   = shift_in;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     rx_data_d  = shift_in;
                     rx_valid_d = 1'b1;
                     phase_d    = 1'b0;
                     state_d    = ST_WR_ACK;
                  end
               end
            end

            ST_WR_ACK: begin
               if (scl_fall) begin
                  if (!phase_q) begin
                     sda_oe_d = 1'b1;
                     phase_d  = 1'b1;
                  end else begin
                     sda_oe_d  = 1'b0;
                     phase_d   = 1'b0;
                     bit_cnt_d = 3'd0;
                     state_d   = ST_WR_BYTE;
                  end
               end
            end

            ST_RD_BYTE: begin
               // The MSB is already on the bus on entry; each fall presents
               // the next bit, and the fall ending bit 0 releases the line.
               if (scl_fall) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     sda_oe_d = 1'b0;
                     phase_d  = 1'b0;
                     state_d  = ST_RD_ACK;
                  end else begin
                     sda_oe_d = ~shift_q[6];
                     shift_d  = {shift_q[6:0], 1'b0};
                  end
               end
            end

            ST_RD_ACK: begin
               if (scl_rise) begin
                  if (sda_sync_q) begin
                     // NACK: the master wants no more data.
                     sda_oe_d = 1'b0;
                     busy_d   = 1'b0;
                     state_d  = ST_IDLE;
                  end else begin
                     phase_d = 1'b1;
                  end
               end else if (scl_fall && phase_q) begin
                  shift_d   = tx_data;
                  tx_req_d  = 1'b1;
                  sda_oe_d  = ~tx_data[7];
                  phase_d   = 1'b0;
                  bit_cnt_d = 3'd0;
                  state_d   = ST_RD_BYTE;
               end
            end

            ST_IDLE, ST_IGNORE: begin
               sda_oe_d = 1'b0;
            end

            default: begin
               sda_oe_d = 1'b0;
               state_d  = ST_IDLE;
            end
         endcase
      end
   end

   // Open-drain output: only ever pull low.
   assign sda = sda_oe_q ? 1'b0 : 1'bz;

   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign tx_req     = tx_req_q;
   assign rw         = rw_q;
   assign busy       = busy_q;
   assign start_tick = start_tick_q;
   assign stop_tick  = stop_tick_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_i2c_slave.sv
`timescale 1ns/1ps
module tb_i2c_slave;

   localparam int Q = 8;   // clk cycles per quarter SCL period

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst;
   logic       scl_m;
   logic       sda_m_low;
   logic [7:0] tx_data = 8'h00;
   wire        sda;
   logic [7:0] rx_data;
   logic       rx_valid, tx_req, rw, busy, start_tick, stop_tick;
   logic [2:0] state_dbg;

   always #5 clk = ~clk;

   pullup p_sda (sda);
   assign sda = sda_m_low ? 1'b0 : 1'bz;

   i2c_slave #(.SLV_ADDR(7'h50)) dut (
      .clk        (clk),
      .rst        (rst),
      .scl        (scl_m),
      .sda        (sda),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .tx_data    (tx_data),
      .tx_req     (tx_req),
      .rw         (rw),
      .busy       (busy),
      .start_tick (start_tick),
      .stop_tick  (stop_tick),
      .state_dbg  (state_dbg)
   );

   // ---------------- scoreboard ----------------
   int         checks = 0;
   int         errors = 0;
   int         n_rx = 0, n_txreq = 0, n_start = 0, n_stop = 0;
   logic [7:0] exp_q[$];
   logic [7:0] tx_next_q[$];   // values the user loads after each tx_req
   logic [7:0] tx_pre_q[$];    // values loaded while no read is running

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [7:0] e;
      if (rx_valid) begin
         n_rx++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL rx_unexpected observed=%0h expected=none", rx_data);
         end else begin
            e = exp_q.pop_front();
            checks++;
            assert (rx_data === e) else begin
               errors++;
               $error("FAIL rx_data observed=%0h expected=%0h", rx_data, e);
            end
         end
      end
      if (tx_req) begin
         n_txreq++;
         if (tx_next_q.size() > 0) tx_data = tx_next_q.pop_front();
      end else if (tx_pre_q.size() > 0) begin
         tx_data = tx_pre_q.pop_front();
      end
      if (start_tick) n_start++;
      if (stop_tick)  n_stop++;
   end

   // ---------------- master driver tasks ----------------
   task automatic qw();
      repeat (Q) @(negedge clk);
   endtask

   task automatic m_start();
      sda_m_low = 1'b0; qw();
      scl_m = 1'b1;     qw();
      sda_m_low = 1'b1; qw();
      scl_m = 1'b0;     qw();
   endtask

   task automatic m_stop();
      sda_m_low = 1'b1; qw();
      scl_m = 1'b1;     qw();
      sda_m_low = 1'b0; qw();
   endtask

   task automatic m_wbit(input logic b);
      sda_m_low = ~b; qw();
      scl_m = 1'b1;   qw(); qw();
      scl_m = 1'b0;   qw();
   endtask

   task automatic m_rbit(output logic b);
      sda_m_low = 1'b0; qw();
      scl_m = 1'b1;     qw();
      b = sda;          qw();
      scl_m = 1'b0;     qw();
   endtask

   task automatic m_wbyte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) m_wbit(d[i]);
      m_rbit(ack);
   endtask

   task automatic m_rbyte(output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         m_rbit(b);
         d[i] = b;
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "simulation timeout");
   end

   // ---------------- directed sequence ----------------
   initial begin
      logic       ack;
      logic       b;
      logic [7:0] d;
      logic [7:0] e;
      int         s0, p0, r0, t0;

      rst = 1'b1;
      scl_m = 1'b1;
      sda_m_low = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_rx_data", 32'(rx_data), 0);
      check("rst_rx_valid", 32'(rx_valid), 0);
      check("rst_tx_req", 32'(tx_req), 0);
      check("rst_rw", 32'(rw), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_start_tick", 32'(start_tick), 0);
      check("rst_stop_tick", 32'(stop_tick), 0);
      check("rst_state", 32'(state_dbg), 0);
      check("rst_sda", 32'(sda), 1);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // 1) write 0x50: A5, 3C, STOP
      s0 = n_start; p0 = n_stop; r0 = n_rx;
      m_start();
      m_wbyte(8'hA0, ack);
      check("t1_addr_ack", 32'(ack), 0);
      check("t1_busy_on", 32'(busy), 1);
      check("t1_rw", 32'(rw), 0);
      exp_q.push_back(8'hA5);
      m_wbyte(8'hA5, ack);
      check("t1_ack_a5", 32'(ack), 0);
      exp_q.push_back(8'h3C);
      m_wbyte(8'h3C, ack);
      check("t1_ack_3c", 32'(ack), 0);
      m_stop();
      check("t1_rx_count", 32'(n_rx - r0), 2);
      check("t1_stop_tick", 32'(n_stop - p0), 1);
      check("t1_start_tick", 32'(n_start - s0), 1);
      check("t1_busy_off", 32'(busy), 0);

      // 2) read 0x50: 0x96 then 0x01, master NACKs the second byte
      tx_pre_q.push_back(8'h96);
      tx_next_q.push_back(8'h01);
      t0 = n_txreq;
      m_start();
      m_wbyte(8'hA1, ack);
      check("t2_addr_ack", 32'(ack), 0);
      check("t2_rw", 32'(rw), 1);
      exp_q.push_back(8'h96);
      m_rbyte(d);
      e = exp_q.pop_front();
      check("t2_byte0", 32'(d), 32'(e));
      m_wbit(1'b0);
      exp_q.push_back(8'h01);
      m_rbyte(d);
      e = exp_q.pop_front();
      check("t2_byte1", 32'(d), 32'(e));
      m_wbit(1'b1);
      check("t2_busy_nack", 32'(busy), 0);
      check("t2_state_idle", 32'(state_dbg), 0);
      check("t2_tx_req_count", 32'(n_txreq - t0), 2);
      m_stop();

      // 3) address 0x51: no ACK, bus left alone until the next START
      r0 = n_rx;
      m_start();
      m_wbyte(8'hA2, ack);
      check("t3_addr_nack", 32'(ack), 1);
      check("t3_busy", 32'(busy), 0);
      check("t3_state_ignore", 32'(state_dbg), 7);
      m_rbyte(d);
      check("t3_bus_idle_byte", 32'(d), 32'hFF);
      m_rbit(b);
      check("t3_bus_idle_ack", 32'(b), 1);
      m_stop();
      check("t3_rx_count", 32'(n_rx - r0), 0);

      // 4) write 0x11, repeated START, read 0xC3
      tx_pre_q.push_back(8'hC3);
      s0 = n_start; r0 = n_rx;
      m_start();
      m_wbyte(8'hA0, ack);
      check("t4_addr_w_ack", 32'(ack), 0);
      check("t4_rw0", 32'(rw), 0);
      exp_q.push_back(8'h11);
      m_wbyte(8'h11, ack);
      check("t4_ack_11", 32'(ack), 0);
      m_start();
      check("t4_start_count", 32'(n_start - s0), 2);
      m_wbyte(8'hA1, ack);
      check("t4_addr_r_ack", 32'(ack), 0);
      check("t4_rw1", 32'(rw), 1);
      exp_q.push_back(8'hC3);
      m_rbyte(d);
      e = exp_q.pop_front();
      check("t4_byte", 32'(d), 32'(e));
      m_wbit(1'b1);
      m_stop();
      check("t4_rx_count", 32'(n_rx - r0), 1);

      // 5) reset while the target holds the address ACK low
      m_start();
      for (int i = 7; i >= 0; i--) m_wbit(1'(8'hA0 >> i));
      sda_m_low = 1'b0; qw();
      scl_m = 1'b1;     qw();
      check("t5_ack_driven", 32'(sda), 0);
      rst = 1'b1;
      #1;
      check("t5_sda_released", 32'(sda), 1);
      check("t5_rx_data", 32'(rx_data), 0);
      check("t5_busy", 32'(busy), 0);
      check("t5_rw", 32'(rw), 0);
      check("t5_state", 32'(state_dbg), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      scl_m = 1'b0; qw();
      m_stop();
      r0 = n_rx;
      m_start();
      m_wbyte(8'hA0, ack);
      check("t5_addr_ack", 32'(ack), 0);
      exp_q.push_back(8'h5A);
      m_wbyte(8'h5A, ack);
      check("t5_ack_5a", 32'(ack), 0);
      m_stop();
      check("t5_rx_count", 32'(n_rx - r0), 1);

      // 6) STOP after four data bits
      r0 = n_rx; p0 = n_stop;
      m_start();
      m_wbyte(8'hA0, ack);
      check("t6_addr_ack", 32'(ack), 0);
      m_wbit(1'b1);
      m_wbit(1'b0);
      m_wbit(1'b1);
      m_wbit(1'b0);
      m_stop();
      check("t6_stop_tick", 32'(n_stop - p0), 1);
      check("t6_rx_count", 32'(n_rx - r0), 0);
      check("t6_state", 32'(state_dbg), 0);
      check("t6_sda", 32'(sda), 1);
      check("t6_busy", 32'(busy), 0);

      check("exp_q_drained", 32'(exp_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- Single-address I2C target (responder) for 7-bit addressing and standard byte transfers.
- Pairs with the team's I2C master on the shared open-drain SCL/SDA bus; serves as the bench-side responder and as an RTL peripheral front end.
- Fully synchronous to clk: oversamples SCL/SDA, detects START/STOP, matches the address, ACKs, and moves bytes over a simple parallel user interface.
- Does not stretch the clock; SCL is input only.

Parameters:
- SLV_ADDR, 7'h50, 7-bit bus address this target answers to.

Ports:
- clk  input  1  system clock; must run at >=16x the SCL frequency.
- rst  input  1  asynchronous active-high reset.
- scl  input  1  bus clock (wire; observed only).
- sda  inout  1  bus data; driven 1'b0 or 'z only, never 1'b1.
- rx_data  output  8  last byte written by the master.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- tx_data  input  8  byte to return on the next master read; user keeps it stable except in the cycle after tx_req.
- tx_req  output  1  one-cycle pulse when tx_data is captured into the shift register.
- rw  output  1  R/W bit of the last matched address (1 = master read).
- busy  output  1  high from address match until STOP, repeated START, or read-NACK.
- start_tick  output  1  one-cycle pulse on any START or repeated START.
- stop_tick  output  1  one-cycle pulse on STOP.

Behaviour:
- Reset values:
  - sda released ('z).
  - rx_data=8'h00, rx_valid=0, tx_req=0, rw=0, busy=0, start_tick=0, stop_tick=0.
  - State = IDLE.
- Synchronizers and edge detect:
  - SCL and SDA each pass through a 2-flop synchronizer, then a registered previous value for edge detection.
  - Bus events therefore appear 3 clk cycles after the pin changes.
- Bus events:
  - START: SDA fall while SCL high.
  - STOP: SDA rise while SCL high.
  - Data bits are sampled on SCL rise.
  - This target changes SDA only in the cycle an SCL fall is detected.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
- Global transitions (apply in any state, highest priority):
  - START: load bit counter 0, release sda, pulse start_tick, go to ADDR.
  - STOP: release sda, clear busy, pulse stop_tick, go to IDLE.
  - If START and STOP were ever coincident, START wins (they cannot be in practice).
- ADDR:
  - Shift 8 bits MSB first.
  - After the 8th SCL rise: if bits[7:1]==SLV_ADDR, latch rw=bit0, set busy, go to ADDR_ACK; otherwise go to IGNORE.
- ADDR_ACK:
  - On the SCL fall ending bit 8, drive sda=0.
  - On the next SCL fall, the ACK ends. If rw=0: release sda, go to WR_BYTE.
  - If rw=1: load tx_data into the shift register, pulse tx_req, drive sda=tx_data[7], go to RD_BYTE.
- WR_BYTE:
  - Shift 8 bits.
  - After the 8th SCL rise: rx_data <= shifted byte, pulse rx_valid (same cycle as the update), go to WR_ACK.
- WR_ACK:
  - Drive sda=0 from the next SCL fall to the following SCL fall, then release and go to WR_BYTE.
  - Every written byte is ACKed; there is no backpressure.
- RD_BYTE:
  - On each SCL fall, drive sda=0 if the current shift bit is 0, else release.
  - After the 8th bit's SCL fall, release sda and go to RD_ACK.
- RD_ACK:
  - Sample SDA on SCL rise.
  - 0 (ACK): on the next SCL fall, reload from tx_data, pulse tx_req, drive the MSB, go to RD_BYTE.
  - 1 (NACK): release, clear busy, go to IDLE.
- IGNORE: sda released; wait for START or STOP.
- IDLE: sda released; only START is acted on.
- Bit counter: 3 bits wide, wraps 7->0 at each byte boundary.
- Reset mid-transfer: sda is released immediately (asynchronous), all outputs clear, and the FSM waits in IDLE for a fresh START.
- Glitch rule: an SDA change while SCL is high outside a START/STOP edge cannot occur after synchronization. Only the rules above apply; there is no separate filter.

Test Plan:
- Write addr 0x50, data 0xA5, 0x3C, STOP -> ACK on address and on both bytes; rx_valid pulses twice with rx_data 0xA5 then 0x3C; stop_tick=1; busy falls.
- Read addr 0x50 with tx_data=0x96; master ACKs, user updates tx_data to 0x01 after tx_req, master NACKs -> bus carries 0x96 then 0x01; tx_req pulses twice; busy clears on NACK.
- Address 0x51 write -> no ACK (SDA stays high on the 9th bit), no rx_valid, busy=0, sda never driven until the next START.
- Write addr 0x50 + byte 0x11, then repeated START to read addr 0x50 with tx_data=0xC3 -> start_tick pulses twice, rw goes 0->1, 0xC3 returned.
- Assert rst while the target drives an ACK low -> sda released within the same cycle, all outputs zero; the next full write transaction completes normally.
- STOP issued mid-byte (after 4 data bits) -> stop_tick=1, no rx_valid, FSM in IDLE, sda released.
